// File: rtl/window_buffer.sv
// Streaming KxK sliding-window generator: K-1 chained line buffers feed the
// right-hand column of a shift-register window; only fully populated windows are flagged valid.
module window_buffer #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                                                   i_clk,
    input  logic                                                   i_rst,
    input  logic [NBIT-1:0]                                        i_pixel,
    input  logic                                                   i_pixel_valid,
    output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] o_data,
    output logic                                                   o_data_valid,
    output logic                                                   o_frame_done
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]                 col_q, col_d;
    logic [RW-1:0]                 row_q, row_d;
    logic                          col_last, row_last;
    logic                          accept;
    logic [NBIT-1:0]               lb_mem [K-1][IMG_WIDTH];
    logic [K-2:0][NBIT-1:0]        tap;
    logic [K-1:0][K-1:0][NBIT-1:0] win_q;
    logic                          data_valid_q;
    logic                          frame_done_q;

    assign accept   = i_pixel_valid;
    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Tap r holds the pixel K-1-r rows above the current column (read-before-write).
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            tap[r] = lb_mem[r][col_q];
        end
    end

    // NOTE: the line-buffer RAM has no reset; the row/column masking keeps stale rows out of valid windows.
    always_ff @(posedge i_clk) begin
        if (accept && !i_rst) begin
            for (int r = 0; r < K - 2; r++) begin
                lb_mem[r][col_q] <= tap[r+1];
            end
            lb_mem[K-2][col_q] <= i_pixel;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            data_valid_q <= accept && (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));
            frame_done_q <= accept && col_last && row_last;
            if (accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                end
                for (int r = 0; r < K - 1; r++) begin
                    win_q[r][K-1] <= tap[r];
                end
                win_q[K-1][K-1] <= i_pixel;
            end
        end
    end

    assign o_data       = win_q;
    assign o_data_valid = data_valid_q;
    assign o_frame_done = frame_done_q;

endmodule
